// File: rtl/window_buffer_stream.sv
// Raster-stream KxK window generator: K-1 line buffers, strided emission, output backpressure
// and frame tracking. Define WB_STREAM_POS_EN to add window grid position outputs.
module window_buffer_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 4,
  parameter int IMG_HEIGHT  = 4,
  parameter int WINDOW_SIZE = 3,
  parameter int STRIDE      = 1
`ifdef WB_STREAM_POS_EN
  ,
  localparam int GRID_H = (IMG_HEIGHT - WINDOW_SIZE) / STRIDE + 1,
  localparam int GRID_W = (IMG_WIDTH - WINDOW_SIZE) / STRIDE + 1,
  localparam int GRW    = (GRID_H > 1) ? $clog2(GRID_H) : 1,
  localparam int GCW    = (GRID_W > 1) ? $clog2(GRID_W) : 1
`endif
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        clear_i,
  input  logic [DATA_WIDTH-1:0]                       data_i,
  input  logic                                        data_valid_i,
  output logic                                        data_ready_o,
  output logic [DATA_WIDTH*WINDOW_SIZE*WINDOW_SIZE-1:0] window_o,
  output logic                                        window_valid_o,
  input  logic                                        window_ready_i,
`ifdef WB_STREAM_POS_EN
  output logic [GRW-1:0]                              win_row_o,
  output logic [GCW-1:0]                              win_col_o,
  output logic                                        win_last_o,
`endif
  output logic                                        frame_done_o
);

  localparam int K  = WINDOW_SIZE;
  localparam int W  = IMG_WIDTH;
  localparam int H  = IMG_HEIGHT;
  localparam int S  = STRIDE;
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int PW = (S > 1) ? $clog2(S) : 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(W - 1);
  localparam logic [CW-1:0] COL_START     = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(H - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(K - 2);
  localparam logic [RW-1:0] ROW_START     = RW'(K - 1);
  localparam logic [PW-1:0] PH_LAST       = PW'(S - 1);

  typedef enum logic {FILL, ACTIVE} state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [PW-1:0]   col_ph;
  logic [PW-1:0]   row_ph;
  logic            accept;
  logic            launch;
  logic            line_end;
  logic            frame_end;

  logic [DW-1:0]   line_mem [K-1][W];
  logic [DW-1:0]   win_sr   [K][K];
  logic [DW-1:0]   win_next [K][K];
  logic [DW*K*K-1:0] win_flat;

  assign data_ready_o = !window_valid_o || window_ready_i;
  assign accept       = data_valid_i && data_ready_o && !clear_i;
  assign line_end     = (col == COL_LAST);
  assign frame_end    = line_end && (row == ROW_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= FILL;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear_i) begin
      state_next = FILL;
    end else if (accept) begin
      case (state)
        FILL:    if (line_end && row == ROW_FILL_LAST) state_next = ACTIVE;
        ACTIVE:  if (frame_end) state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  always_comb begin
    launch = 1'b0;
    if (accept && state == ACTIVE && col >= COL_START && col_ph == '0 && row_ph == '0)
      launch = 1'b1;
  end

  // Phases only advance once the window fits, so phase 0 marks every S-th window origin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
    end else if (clear_i) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
    end else if (accept) begin
      if (line_end) begin
        col    <= '0;
        col_ph <= '0;
        if (frame_end) begin
          row    <= '0;
          row_ph <= '0;
        end else begin
          row <= row + 1'b1;
          if (row >= ROW_START) row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        if (col >= COL_START) col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K - 1; j++)
        win_next[i][j] = win_sr[i][j+1];
    for (int i = 0; i < K - 1; i++)
      win_next[i][K-1] = line_mem[i][col];
    win_next[K-1][K-1] = data_i;
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        win_flat[(i*K+j)*DW +: DW] = win_next[i][j];
  end

  // Line 0 holds the oldest buffered row; each accept shifts one column up by a line.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < K - 2; i++)
        line_mem[i][col] <= line_mem[i+1][col];
      line_mem[K-2][col] <= data_i;
      win_sr <= win_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      window_o       <= '0;
      window_valid_o <= 1'b0;
      frame_done_o   <= 1'b0;
    end else if (clear_i) begin
      window_valid_o <= 1'b0;
      frame_done_o   <= 1'b0;
    end else begin
      frame_done_o <= accept && frame_end;
      if (launch) begin
        window_o       <= win_flat;
        window_valid_o <= 1'b1;
      end else if (window_ready_i) begin
        window_valid_o <= 1'b0;
      end
    end
  end

`ifdef WB_STREAM_POS_EN
  localparam logic [GRW-1:0] GROW_LAST = GRW'(GRID_H - 1);
  localparam logic [GCW-1:0] GCOL_LAST = GCW'(GRID_W - 1);

  logic [GRW-1:0] grid_row;
  logic [GCW-1:0] grid_col;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grid_row   <= '0;
      grid_col   <= '0;
      win_row_o  <= '0;
      win_col_o  <= '0;
      win_last_o <= 1'b0;
    end else if (clear_i) begin
      grid_row <= '0;
      grid_col <= '0;
    end else if (launch) begin
      win_row_o  <= grid_row;
      win_col_o  <= grid_col;
      win_last_o <= (grid_row == GROW_LAST) && (grid_col == GCOL_LAST);
      if (grid_col == GCOL_LAST) begin
        grid_col <= '0;
        grid_row <= (grid_row == GROW_LAST) ? '0 : grid_row + 1'b1;
      end else begin
        grid_col <= grid_col + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/window_buffer_stream.md
Name: window_buffer_stream

Overview:
- Parametrised successor to the 3x3 line-buffer window generator used ahead of the CNN convolution engine.
- Accepts a raster-order pixel stream through a valid/ready handshake and buffers K-1 full lines.
- Emits KxK windows at a configurable stride, with output backpressure, frame tracking and synchronous frame restart.
- Sits between the image source (camera/SW test feeder) and the conv MAC array.

Parameters:
DATA_WIDTH, 8, bits per pixel
IMG_WIDTH, 4, pixels per line (W)
IMG_HEIGHT, 4, lines per frame (H)
WINDOW_SIZE, 3, window edge K; 2 <= K <= min(W,H)
STRIDE, 1, window step S in both axes; S >= 1

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous frame restart
data_i  in  DATA_WIDTH  input pixel
data_valid_i  in  1  pixel valid
data_ready_o  out  1  block can accept pixel
window_o  out  DATA_WIDTH*K*K  flattened window
window_valid_o  out  1  window_o holds a valid window
window_ready_i  in  1  consumer accepts window
frame_done_o  out  1  one-cycle pulse, last pixel of frame accepted

Behaviour:
- One clock, clk_i. Reset is asynchronous, active-low, on rst_ni.
- Reset: row/col counters = 0, stride phase counters = 0, window_o = 0, window_valid_o = 0, frame_done_o = 0. Line-buffer RAM is not cleared.
- Accept condition: data_valid_i && data_ready_o.
- data_ready_o = !window_valid_o || window_ready_i (combinational), so it reads 1 right after reset.
- Counters: col wraps W-1 -> 0 and increments row; row wraps H-1 -> 0. Wrap at end of frame also resets stride phases.
- States:
  - FILL: row < K-1; accepted pixels only enter the line buffers.
  - ACTIVE: row >= K-1; windows are produced.
  - Transition FILL -> ACTIVE on accepting pixel (K-2, W-1).
  - Transition ACTIVE -> FILL on accepting pixel (H-1, W-1), which ends the frame.
- Emit rule: accepting pixel (r,c) launches a window iff r >= K-1, c >= K-1, (r-K+1) mod S == 0 and (c-K+1) mod S == 0. Modulo is tracked with phase counters; no divider.
- Latency: window_o and window_valid_o are registered and appear 1 cycle after the launching accept.
- Layout: element e = i*K+j (i row, j col within window) = pixel (r-K+1+i, c-K+1+j), at window_o[e*DATA_WIDTH +: DATA_WIDTH].
- Windows per frame: ((H-K)/S+1) * ((W-K)/S+1) (integer division).
- Backpressure: while window_valid_o && !window_ready_i, window_o is held stable, data_ready_o = 0, and no state changes.
- Simultaneous drain and launch: window_ready_i=1 with a launching accept in the same cycle loads the new window; valid stays 1 with no bubble.
- Drain without launch: valid drops to 0 next cycle.
- frame_done_o: pulses on the cycle after accepting pixel (H-1, W-1).
- Frames: back-to-back frames need no gap. Stale lines from the previous frame never appear in a window because the FILL state gates emission.
- clear_i:
  - Drops window_valid_o and resets all counters and phases next cycle.
  - Overrides a simultaneous accept; that pixel is discarded.
  - data_ready_o stays governed by its normal equation.
- Async reset mid-frame: behaves exactly like clear_i but takes effect immediately.

Optional Feature:
- Macro WB_STREAM_POS_EN.
- Defined: adds outputs win_row_o and win_col_o, each clog2-sized to the window-grid height/width. They are registered with window_o and give the window's grid index (0-based, stride-scaled). Adds win_last_o, high with the final window of a frame. All three reset to 0.
- Undefined: these ports and their logic are absent. Core behaviour is identical.

Test Plan:
- Config W=H=4, K=3, S=1; feed pixels 0..15 with valid held high and window_ready_i=1.
  -> 4 windows.
  -> First window is valid the cycle after pixel 10 and equals {0,1,2,4,5,6,8,9,10}.
  -> Last window is {5,6,7,9,10,11,13,14,15}.
  -> frame_done_o pulses once.
- Config W=H=5, K=3, S=2; feed 0..24.
  -> Exactly 4 windows, launched by pixels 12, 14, 22, 24.
  -> First window is {0,1,2,5,6,7,10,11,12}.
- Backpressure: same as scenario 1, but hold window_ready_i=0 for 5 cycles after the first window.
  -> window_o stays stable, data_ready_o=0, no pixel is lost.
  -> Remaining windows match the scenario-1 values.
- Back-to-back frames: feed 0..15 immediately followed by 100..115.
  -> 8 windows total.
  -> Second frame's first window is {100,101,102,104,105,106,108,109,110}.
- Mid-frame restart: pulse rst_ni low after pixel 7, then feed 0..15.
  -> Outputs are 0 during reset and exactly scenario-1 windows follow.
- Repeat the mid-frame restart with clear_i instead of rst_ni, asserting clear_i coincident with pixel 8.
  -> Pixel 8 is discarded and results are identical to the rst_ni case.
